// File: rtl/word_frame_assembler_if.sv
// ---------------------------------------------------------------------------
// word_frame_assembler_if
//
// Purpose: bundles the word-input and frame-output handshakes of
// word_frame_assembler into one interface.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid & ready are both 1. A producer holding valid keeps its data
// stable until the transfer. ready never depends on valid, and valid never
// depends on ready.
//
// Signals:
//   in_word          Width         incoming word
//   in_valid         1             in_word is valid this cycle
//   in_ready         1             block accepts in_word this cycle
//   MSword_In_First  1             frame order, sampled on a frame's first word
//   flush            1             discard the partially assembled frame
//   out_frame        Length*Width  assembled frame (registered)
//   out_valid        1             out_frame holds an unconsumed frame
//   out_ready        1             consumer accepts out_frame
//   word_count       Cnt_Width     words accepted into the current partial frame
//
// Modports:
//   master  -- the environment: drives words, order, flush and out_ready
//   slave   -- the assembler
// ---------------------------------------------------------------------------
interface word_frame_assembler_if #(
  parameter int Length    = 4,
  parameter int Width     = 8,
  parameter int Cnt_Width = 3
);

  logic [Width-1:0]        in_word;
  logic                    in_valid;
  logic                    in_ready;
  logic                    MSword_In_First;
  logic                    flush;
  logic [Length*Width-1:0] out_frame;
  logic                    out_valid;
  logic                    out_ready;
  logic [Cnt_Width-1:0]    word_count;

  modport master (
    output in_word,
    output in_valid,
    output MSword_In_First,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_frame,
    input  out_valid,
    input  word_count
  );

  modport slave (
    input  in_word,
    input  in_valid,
    input  MSword_In_First,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_frame,
    output out_valid,
    output word_count
  );

endinterface

// File: rtl/word_frame_assembler.sv
// ---------------------------------------------------------------------------
// word_frame_assembler
//
// Purpose: receive-side partner of the word-serial shift register. Collects
// Length words of Width bits into one parallel frame. Word order is chosen
// per frame (MS word first or LS word first). A one-frame output holding
// register lets the next frame assemble while the consumer still holds the
// previous one; if a second frame completes before the first is consumed,
// the block parks it in the assembly register (state HOLD) and stops
// accepting words until the output slot frees up.
//
// Ports:
//   clk          rising-edge clock
//   sres         synchronous active-high reset, overrides everything
//   bus          word_frame_assembler_if.slave (words in, frames out)
//   dbg_state_o  current FSM state: 0 = COLLECT, 1 = HOLD
//
// Parameters:
//   Length     words per frame (>= 1)
//   Width      bits per word (>= 1)
//   Cnt_Width  word-counter width, 2**Cnt_Width must exceed Length
// ---------------------------------------------------------------------------
module word_frame_assembler #(
  parameter int Length    = 4,
  parameter int Width     = 8,
  parameter int Cnt_Width = 3
) (
  input  logic                    clk,
  input  logic                    sres,
  word_frame_assembler_if.slave   bus,
  output logic                    dbg_state_o
);

  localparam int FW = Length * Width;

  // Counter value of the last word of a frame, and the value parked in HOLD.
  localparam logic [Cnt_Width-1:0] LAST_IDX = Cnt_Width'(Length - 1);
  localparam logic [Cnt_Width-1:0] FULL_CNT = Cnt_Width'(Length);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e               state_q, state_d;

  logic [FW-1:0]        asm_q, asm_d;
  logic [FW-1:0]        out_frame_q, out_frame_d;
  logic                 out_valid_q, out_valid_d;
  logic                 order_q, order_d;
  logic [Cnt_Width-1:0] cnt_q, cnt_d;

  logic                 in_ready_w;
  logic                 accept;
  logic                 out_take;
  logic                 last_word;
  logic                 can_load;
  logic                 frame_order;
  logic [FW-1:0]        asm_shift;

  // -------------------------------------------------------------------------
  // Handshake qualifiers
  // -------------------------------------------------------------------------
  // in_ready is a function of state and flush only, never of in_valid.
  assign in_ready_w = (state_q == COLLECT) && !bus.flush;
  assign accept     = bus.in_valid && in_ready_w;
  assign out_take   = out_valid_q && bus.out_ready;
  assign last_word  = (cnt_q == LAST_IDX);

  // The output slot can take a freshly completed frame if it is empty or is
  // being consumed on this very edge.
  assign can_load   = !out_valid_q || out_take;

  // On a frame's first word the order input is used directly so the new
  // order applies on the same cycle it is latched.
  assign frame_order = (cnt_q == '0) ? bus.MSword_In_First : order_q;

  // Assembly register after shifting in the current word.
  generate
    if (Length == 1) begin : g_single_word
      assign asm_shift = bus.in_word;
    end else begin : g_multi_word
      // MS-first pushes earlier words toward the MSB; LS-first pushes them
      // toward the LSB so the first word ends up in the lowest slot.
      assign asm_shift = frame_order ? {asm_q[FW-Width-1:0], bus.in_word}
                                     : {bus.in_word, asm_q[FW-1:Width]};
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sres) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
        // A completed frame with nowhere to go is parked in the assembly
        // register; flush suppresses accept, so it cannot reach here.
        if (accept && last_word && !can_load) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_take) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.in_ready   = in_ready_w;
    bus.out_frame  = out_frame_q;
    bus.out_valid  = out_valid_q;
    bus.word_count = cnt_q;
    dbg_state_o    = (state_q == HOLD);
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    asm_d       = asm_q;
    out_frame_d = out_frame_q;
    out_valid_d = out_valid_q;
    order_d     = order_q;
    cnt_d       = cnt_q;

    // Consumption empties the output slot unless a load below refills it.
    if (out_take) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      COLLECT: begin
        if (bus.flush) begin
          // Only the partial frame is discarded; the output slot is untouched.
          cnt_d = '0;
          asm_d = '0;
        end else if (accept) begin
          asm_d = asm_shift;
          if (cnt_q == '0) begin
            order_d = bus.MSword_In_First;
          end
          if (last_word) begin
            if (can_load) begin
              // Back-to-back path: next frame may start on the next cycle.
              out_frame_d = asm_shift;
              out_valid_d = 1'b1;
              cnt_d       = '0;
            end else begin
              cnt_d = FULL_CNT;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // flush is deliberately ignored: the parked frame is complete.
        if (out_take) begin
          out_frame_d = asm_q;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sres) begin
      asm_q       <= '0;
      out_frame_q <= '0;
      out_valid_q <= 1'b0;
      order_q     <= 1'b1;
      cnt_q       <= '0;
    end else begin
      asm_q       <= asm_d;
      out_frame_q <= out_frame_d;
      out_valid_q <= out_valid_d;
      order_q     <= order_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_word_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_word_frame_assembler
//
// Drives word_frame_assembler through directed scenarios and a randomized
// phase. A reference model built from queues tracks partial words and
// completed-but-unconsumed frames; every cycle the DUT outputs are compared
// against it, and the directed scenarios add fixed expected frame values.
// ---------------------------------------------------------------------------
module tb_word_frame_assembler;

  localparam int L  = 4;
  localparam int W  = 8;
  localparam int CW = 3;
  localparam int FW = L * W;

  logic clk = 1'b0;
  logic sres;
  logic dbg_state;

  always #5 clk = ~clk;

  word_frame_assembler_if #(.Length(L), .Width(W), .Cnt_Width(CW)) bus ();

  word_frame_assembler #(.Length(L), .Width(W), .Cnt_Width(CW)) dut (
    .clk         (clk),
    .sres        (sres),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Reference model state
  logic [W-1:0]  cur_q[$];     // words of the frame being assembled
  bit            cur_ms;       // order latched for that frame
  logic [FW-1:0] exp_q[$];     // completed frames not yet consumed
  logic [FW-1:0] last_frame;   // last frame shown while the slot is empty

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cur_q.delete();
    exp_q.delete();
    cur_ms     = 1'b1;
    last_frame = '0;
  endtask

  // One clock cycle: apply inputs, compare DUT against the model, then let
  // the model absorb the transfers that happen on the coming edge.
  task automatic drive(input bit v, input logic [W-1:0] w, input bit ms,
                       input bit fl, input bit ordy, input string tag,
                       output bit acc);
    bit            full2;
    bit            exp_ready;
    bit            take;
    logic [FW-1:0] frame;
    @(negedge clk);
    bus.in_valid        = v;
    bus.in_word         = w;
    bus.MSword_In_First = ms;
    bus.flush           = fl;
    bus.out_ready       = ordy;
    #1;
    full2     = (exp_q.size() == 2);
    exp_ready = !fl && !full2;
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_ready));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_q.size() > 0));
    check({tag, ".out_frame"}, 64'(bus.out_frame),
          64'((exp_q.size() > 0) ? exp_q[0] : last_frame));
    check({tag, ".word_count"}, 64'(bus.word_count),
          full2 ? 64'(L) : 64'(cur_q.size()));
    check({tag, ".held"}, 64'(dbg_state), 64'(full2));

    acc  = v && exp_ready;
    take = ordy && (exp_q.size() > 0);
    if (take) last_frame = exp_q.pop_front();
    if (fl && !full2) cur_q.delete();
    if (acc) begin
      if (cur_q.size() == 0) cur_ms = ms;
      cur_q.push_back(w);
      if (cur_q.size() == L) begin
        frame = '0;
        for (int i = 0; i < L; i++) begin
          if (cur_ms) frame = frame | (FW'(cur_q[i]) << (W * (L - 1 - i)));
          else        frame = frame | (FW'(cur_q[i]) << (W * i));
        end
        exp_q.push_back(frame);
        cur_q.delete();
      end
    end
  endtask

  // Move to just after the edge so the result of the last drive is visible.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sres         = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    sres = 1'b0;
    model_reset();
    #1;
  endtask

  logic [W-1:0] wv [4];
  bit           acc;
  bit           pend;
  logic [W-1:0] pw;
  bit           r_ms, r_fl, r_ordy;

  initial begin
    sres                = 1'b1;
    bus.in_word         = '0;
    bus.in_valid        = 1'b0;
    bus.MSword_In_First = 1'b1;
    bus.flush           = 1'b0;
    bus.out_ready       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Reset state
    check("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check("reset.out_frame", 64'(bus.out_frame), 64'd0);
    check("reset.word_count", 64'(bus.word_count), 64'd0);
    check("reset.in_ready", 64'(bus.in_ready), 64'd1);

    // MS first
    wv = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) drive(1, wv[i], 1, 0, 1, "ms", acc);
    settle();
    check("ms.valid", 64'(bus.out_valid), 64'd1);
    check("ms.frame", 64'(bus.out_frame), 64'h11223344);
    drive(0, 0, 1, 0, 1, "ms.drain", acc);
    settle();
    check("ms.one_cycle", 64'(bus.out_valid), 64'd0);

    // LS first
    for (int i = 0; i < 4; i++) drive(1, wv[i], 0, 0, 1, "ls", acc);
    settle();
    check("ls.frame", 64'(bus.out_frame), 64'h44332211);
    drive(0, 0, 1, 0, 1, "ls.drain", acc);

    // Backpressure: second frame parks until the output is consumed
    for (int i = 1; i <= 8; i++) drive(1, W'(i), 1, 0, 0, "bp", acc);
    settle();
    check("bp.frame1", 64'(bus.out_frame), 64'h01020304);
    check("bp.hold_ready", 64'(bus.in_ready), 64'd0);
    check("bp.hold_count", 64'(bus.word_count), 64'd4);
    drive(0, 0, 1, 0, 1, "bp.pulse", acc);
    settle();
    check("bp.frame2", 64'(bus.out_frame), 64'h05060708);
    check("bp.valid2", 64'(bus.out_valid), 64'd1);
    check("bp.ready2", 64'(bus.in_ready), 64'd1);
    drive(0, 0, 1, 0, 1, "bp.drain", acc);

    // Flush mid-frame
    drive(1, 8'hAA, 1, 0, 1, "fl", acc);
    drive(1, 8'hBB, 1, 0, 1, "fl", acc);
    drive(1, 8'hCC, 1, 1, 1, "fl.flush", acc);
    settle();
    check("fl.count", 64'(bus.word_count), 64'd0);
    for (int i = 1; i <= 4; i++) drive(1, W'(i), 1, 0, 1, "fl.after", acc);
    settle();
    check("fl.frame", 64'(bus.out_frame), 64'h01020304);
    drive(0, 0, 1, 0, 1, "fl.drain", acc);

    // Order latched only on the first word
    wv = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    drive(1, wv[0], 1, 0, 1, "ord", acc);
    for (int i = 1; i < 4; i++) drive(1, wv[i], 0, 0, 1, "ord", acc);
    settle();
    check("ord.frame", 64'(bus.out_frame), 64'hA1B2C3D4);
    drive(0, 0, 1, 0, 1, "ord.drain", acc);

    // Reset with a held frame plus a partial frame
    for (int i = 0; i < 6; i++) drive(1, W'(8'h10 + i), 1, 0, 0, "rst.fill", acc);
    settle();
    check("rst.pre_count", 64'(bus.word_count), 64'd2);
    check("rst.pre_valid", 64'(bus.out_valid), 64'd1);
    do_reset();
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.out_frame", 64'(bus.out_frame), 64'd0);
    check("rst.word_count", 64'(bus.word_count), 64'd0);
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) drive(1, W'(8'h21 + i), 1, 0, 1, "rst.after", acc);
    settle();
    check("rst.frame", 64'(bus.out_frame), 64'h21222324);
    drive(0, 0, 1, 0, 1, "rst.drain", acc);

    // Randomized traffic; a presented word stays put until accepted
    pend = 1'b0;
    pw   = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pw   = W'($urandom);
      end
      r_ms   = 1'($urandom_range(0, 1));
      r_fl   = ($urandom_range(0, 24) == 0);
      r_ordy = (c < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(pend, pw, r_ms, r_fl, r_ordy, "rand", acc);
      if (acc) pend = 1'b0;
      if (c == 900) begin
        do_reset();
        pend = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 1, "final", acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
